// File: rtl/sfp_acc_pipe_if.sv
// rtl/sfp_acc_pipe_if.sv - beat input / result output bundle of the accumulate-ReLU stage
interface sfp_acc_pipe_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int cnt_bw  = 6
);
  logic [psum_bw*col-1:0] in;
  logic                   valid_in;
  logic                   ready_out;
  logic [cnt_bw-1:0]      acc_len;
  logic                   relu_en;
  logic                   flush;
  logic [psum_bw*col-1:0] out;
  logic                   valid_out;
  logic                   ready_in;
  logic [cnt_bw-1:0]      acc_cnt;
  logic                   sat_flag;

  modport slave (
    input  in, valid_in, acc_len, relu_en, flush, ready_in,
    output ready_out, out, valid_out, acc_cnt, sat_flag
  );

  modport master (
    output in, valid_in, acc_len, relu_en, flush, ready_in,
    input  ready_out, out, valid_out, acc_cnt, sat_flag
  );
endinterface

// File: rtl/sfp_acc_pipe.sv
// rtl/sfp_acc_pipe.sv - per-column grouped accumulate, optional ReLU, narrow to psum_bw
// Optional saturating narrow and sat_flag under macro SFP_ACC_SAT_EN.
module sfp_acc_pipe #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int acc_bw  = 24,
  parameter int cnt_bw  = 6
) (
  input logic          clk,
  input logic          reset,
  sfp_acc_pipe_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t                   state, state_nx;
  logic signed [acc_bw-1:0] acc [col];
  logic signed [acc_bw-1:0] sum [col];
  logic [cnt_bw-1:0]        cnt, cnt_nx, len_q, len_nx, len_in, eff_len, new_cnt;
  logic                     relu_q, relu_nx, relu_eff;
  logic [psum_bw*col-1:0]   out_q, res;
  logic                     accept, first, close;

  assign bus.ready_out = (state != HOLD) || bus.ready_in;
  assign accept        = bus.valid_in && bus.ready_out;
  // Outside ACC any accepted beat opens a fresh group (HOLD only accepts while retiring).
  assign first         = (state != ACC);
  assign len_in        = (bus.acc_len == '0) ? cnt_bw'(1) : bus.acc_len;
  assign eff_len       = first ? len_in : len_q;
  assign relu_eff      = first ? bus.relu_en : relu_q;
  assign new_cnt       = first ? cnt_bw'(1) : cnt + cnt_bw'(1);
  assign close         = (accept && (new_cnt == eff_len)) || ((state == ACC) && bus.flush);

`ifdef SFP_ACC_SAT_EN
  logic [col-1:0] clip_v;
  logic           sat_q;
  localparam logic signed [acc_bw-1:0] max_v = {{(acc_bw-psum_bw+1){1'b0}}, {(psum_bw-1){1'b1}}};
  localparam logic signed [acc_bw-1:0] min_v = ~max_v;
`endif

  for (genvar g = 0; g < col; g++) begin : g_lane
    logic signed [psum_bw-1:0] beat;
    logic signed [acc_bw-1:0]  base, addend;

    assign beat   = bus.in[psum_bw*g +: psum_bw];
    assign base   = (accept && first) ? '0 : acc[g];
    assign addend = accept ? acc_bw'(beat) : '0;
    assign sum[g] = base + addend;

`ifdef SFP_ACC_SAT_EN
    logic signed [acc_bw-1:0] r;
    assign r         = (relu_eff && sum[g][acc_bw-1]) ? '0 : sum[g];
    assign clip_v[g] = (r > max_v) || (r < min_v);
    assign res[psum_bw*g +: psum_bw] = (r > max_v) ? max_v[psum_bw-1:0] :
                                       (r < min_v) ? min_v[psum_bw-1:0] : r[psum_bw-1:0];
`else
    // ReLU decision uses the full-width sign, then the low bits are kept.
    assign res[psum_bw*g +: psum_bw] = (relu_eff && sum[g][acc_bw-1]) ? '0 : sum[g][psum_bw-1:0];
`endif
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    len_nx   = len_q;
    relu_nx  = relu_q;
    case (state)
      IDLE:    if (accept) state_nx = close ? HOLD : ACC;
      ACC:     if (close) state_nx = HOLD;
      HOLD:    if (bus.ready_in) state_nx = accept ? (close ? HOLD : ACC) : IDLE;
      default: state_nx = IDLE;
    endcase
    if (accept) begin
      cnt_nx = new_cnt;
      if (first) begin
        len_nx  = len_in;
        relu_nx = bus.relu_en;
      end
    end
    if (close) cnt_nx = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      len_q  <= cnt_bw'(1);
      relu_q <= 1'b0;
      out_q  <= '0;
      for (int i = 0; i < col; i++) acc[i] <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      len_q  <= len_nx;
      relu_q <= relu_nx;
      if (close) out_q <= res;
      if (accept) begin
        for (int i = 0; i < col; i++) acc[i] <= sum[i];
      end
    end
  end

`ifdef SFP_ACC_SAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     sat_q <= 1'b0;
    else if (close) sat_q <= |clip_v;
  end
  assign bus.sat_flag = sat_q;
`else
  assign bus.sat_flag = 1'b0;
`endif

  assign bus.out       = out_q;
  assign bus.valid_out = (state == HOLD);
  assign bus.acc_cnt   = cnt;

endmodule

// File: tb/tb_sfp_acc_pipe.sv
// tb/tb_sfp_acc_pipe.sv - directed vector bench for sfp_acc_pipe
module tb_sfp_acc_pipe;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  sfp_acc_pipe_if #(.col(8), .psum_bw(16), .cnt_bw(6)) bus ();

  sfp_acc_pipe #(.col(8), .psum_bw(16), .acc_bw(24), .cnt_bw(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [5:0]  len;
    logic        relu;
    int          nb;
    logic        fl;
    int          b0 [4];
    int          b1 [4];
    int          b7 [4];
    logic [15:0] e0, e1, e7;
    logic        es;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int a0, input int a1, input int a7);
    bus.in          = '0;
    bus.in[15:0]    = a0[15:0];
    bus.in[31:16]   = a1[15:0];
    bus.in[127:112] = a7[15:0];
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    bus.ready_in = 1'b1;
    for (int k = 0; k < v.nb; k++) begin
      set_beat(v.b0[k], v.b1[k], v.b7[k]);
      // Later beats present different acc_len/relu_en to check they stay latched.
      bus.acc_len  = (k == 0) ? v.len : (v.len ^ 6'h3);
      bus.relu_en  = (k == 0) ? v.relu : ~v.relu;
      bus.valid_in = 1'b1;
      step();
      if (k < v.nb - 1 || v.fl) begin
        chk($sformatf("v%0d acc_cnt beat%0d", idx, k), 128'(bus.acc_cnt), 128'(k + 1));
        chk($sformatf("v%0d valid_out early%0d", idx, k), 128'(bus.valid_out), 128'(0));
      end
    end
    bus.valid_in = 1'b0;
    if (v.fl) begin
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
    end
    chk($sformatf("v%0d valid_out", idx), 128'(bus.valid_out), 128'(1));
    chk($sformatf("v%0d acc_cnt close", idx), 128'(bus.acc_cnt), 128'(0));
    chk($sformatf("v%0d out", idx), bus.out, {v.e7, 80'h0, v.e1, v.e0});
    chk($sformatf("v%0d sat_flag", idx), 128'(bus.sat_flag), 128'(v.es));
    step();
    chk($sformatf("v%0d retire", idx), 128'(bus.valid_out), 128'(0));
  endtask

  initial begin
    vecs[0] = '{len: 6'd1, relu: 1'b0, nb: 1, fl: 1'b0, b0: '{-5, 0, 0, 0}, b1: '{0, 0, 0, 0},
                b7: '{300, 0, 0, 0}, e0: 16'hFFFB, e1: 16'h0000, e7: 16'h012C, es: 1'b0};
    vecs[1] = '{len: 6'd4, relu: 1'b0, nb: 4, fl: 1'b0, b0: '{10, -3, 7, -20}, b1: '{1, 2, 3, 4},
                b7: '{-1, -1, -1, -1}, e0: 16'hFFFA, e1: 16'h000A, e7: 16'hFFFC, es: 1'b0};
    vecs[2] = '{len: 6'd4, relu: 1'b1, nb: 4, fl: 1'b0, b0: '{10, -3, 7, -20}, b1: '{1, 2, 3, 4},
                b7: '{-1, -1, -1, -1}, e0: 16'h0000, e1: 16'h000A, e7: 16'h0000, es: 1'b0};
    vecs[3] = '{len: 6'd4, relu: 1'b0, nb: 2, fl: 1'b1, b0: '{100, 200, 0, 0}, b1: '{-1, -2, 0, 0},
                b7: '{0, 0, 0, 0}, e0: 16'h012C, e1: 16'hFFFD, e7: 16'h0000, es: 1'b0};
`ifdef SFP_ACC_SAT_EN
    vecs[4] = '{len: 6'd2, relu: 1'b0, nb: 2, fl: 1'b0, b0: '{30000, 30000, 0, 0}, b1: '{-30000, -30000, 0, 0},
                b7: '{1, 2, 0, 0}, e0: 16'h7FFF, e1: 16'h8000, e7: 16'h0003, es: 1'b1};
    vecs[7] = '{len: 6'd2, relu: 1'b1, nb: 2, fl: 1'b0, b0: '{30000, 30000, 0, 0}, b1: '{-30000, -30000, 0, 0},
                b7: '{0, 0, 0, 0}, e0: 16'h7FFF, e1: 16'h0000, e7: 16'h0000, es: 1'b1};
`else
    vecs[4] = '{len: 6'd2, relu: 1'b0, nb: 2, fl: 1'b0, b0: '{30000, 30000, 0, 0}, b1: '{-30000, -30000, 0, 0},
                b7: '{1, 2, 0, 0}, e0: 16'hEA60, e1: 16'h15A0, e7: 16'h0003, es: 1'b0};
    vecs[7] = '{len: 6'd2, relu: 1'b1, nb: 2, fl: 1'b0, b0: '{30000, 30000, 0, 0}, b1: '{-30000, -30000, 0, 0},
                b7: '{0, 0, 0, 0}, e0: 16'hEA60, e1: 16'h0000, e7: 16'h0000, es: 1'b0};
`endif
    vecs[5] = '{len: 6'd0, relu: 1'b1, nb: 1, fl: 1'b0, b0: '{-7, 0, 0, 0}, b1: '{7, 0, 0, 0},
                b7: '{-32768, 0, 0, 0}, e0: 16'h0000, e1: 16'h0007, e7: 16'h0000, es: 1'b0};
    vecs[6] = '{len: 6'd3, relu: 1'b1, nb: 3, fl: 1'b0, b0: '{-100, 50, 60, 0}, b1: '{-1, -1, -1, 0},
                b7: '{-1, -1, 5, 0}, e0: 16'h000A, e1: 16'h0000, e7: 16'h0003, es: 1'b0};

    reset        = 1'b0;
    bus.in       = '0;
    bus.valid_in = 1'b0;
    bus.acc_len  = 6'd1;
    bus.relu_en  = 1'b0;
    bus.flush    = 1'b0;
    bus.ready_in = 1'b0;
    step();
    step();
    chk("rst valid_out", 128'(bus.valid_out), 128'(0));
    chk("rst acc_cnt", 128'(bus.acc_cnt), 128'(0));
    chk("rst out", bus.out, 128'(0));
    chk("rst sat_flag", 128'(bus.sat_flag), 128'(0));
    chk("rst ready_out", 128'(bus.ready_out), 128'(1));
    reset = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_vec(i);

    // Back-to-back single-beat groups: one result per cycle.
    bus.ready_in = 1'b1;
    bus.acc_len  = 6'd1;
    bus.relu_en  = 1'b0;
    bus.valid_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      set_beat(k, 0, 0);
      step();
      chk($sformatf("b2b valid_out %0d", k), 128'(bus.valid_out), 128'(1));
      chk($sformatf("b2b out %0d", k), bus.out, 128'(k));
      chk($sformatf("b2b ready_out %0d", k), 128'(bus.ready_out), 128'(1));
    end

    // Backpressure on the pending result of 3.
    bus.ready_in = 1'b0;
    bus.acc_len  = 6'd2;
    set_beat(99, 0, 0);
    #1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("bp ready_out %0d", k), 128'(bus.ready_out), 128'(0));
      chk($sformatf("bp valid_out %0d", k), 128'(bus.valid_out), 128'(1));
      chk($sformatf("bp out %0d", k), bus.out, 128'(3));
      chk($sformatf("bp acc_cnt %0d", k), 128'(bus.acc_cnt), 128'(0));
    end
    bus.ready_in = 1'b1;
    #1;
    chk("bp release ready_out", 128'(bus.ready_out), 128'(1));
    step();
    chk("bp retire valid_out", 128'(bus.valid_out), 128'(0));
    chk("bp beat accepted", 128'(bus.acc_cnt), 128'(1));
    set_beat(1, 0, 0);
    step();
    chk("bp group valid_out", 128'(bus.valid_out), 128'(1));
    chk("bp group out", bus.out, 128'(100));
    bus.valid_in = 1'b0;
    step();

    // Flush while idle does nothing.
    bus.flush = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("idle flush valid_out %0d", k), 128'(bus.valid_out), 128'(0));
      chk($sformatf("idle flush acc_cnt %0d", k), 128'(bus.acc_cnt), 128'(0));
    end
    bus.flush = 1'b0;

    // Asynchronous reset mid-group discards partial sums.
    bus.acc_len  = 6'd1;
    bus.valid_in = 1'b1;
    set_beat(55, 0, 0);
    step();
    chk("pre-rst out", bus.out, 128'(55));
    bus.acc_len = 6'd4;
    set_beat(1000, 0, 0);
    step();
    step();
    chk("pre-rst acc_cnt", 128'(bus.acc_cnt), 128'(2));
    bus.valid_in = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async rst valid_out", 128'(bus.valid_out), 128'(0));
    chk("async rst acc_cnt", 128'(bus.acc_cnt), 128'(0));
    chk("async rst out", bus.out, 128'(0));
    bus.valid_in = 1'b1;
    set_beat(500, 0, 0);
    step();
    chk("rst beat ignored", 128'(bus.acc_cnt), 128'(0));
    reset = 1'b1;
    set_beat(1, 0, 0);
    for (int k = 0; k < 4; k++) step();
    bus.valid_in = 1'b0;
    chk("post-rst valid_out", 128'(bus.valid_out), 128'(1));
    chk("post-rst out", bus.out, 128'(4));
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
